mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Moore FSM sequencing the multicycle MIPS datapath: memory, IR, PC, register file, ALU, and the immediate extender.
//  Per instruction it selects sign or zero extension (extop) and the ALU B source, including extended imm and imm<<2.
//  Sits beside the datapath; op comes from the IR, and mem_ready paces the shared instruction/data memory.
// PARAMETERS
//  MEM_HANDSHAKE  1  1: memory states wait for mem_ready; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk          in   1  single clock, rising edge
//  reset_n      in   1  asynchronous, active-low reset
//  op           in   6  IR[31:26] opcode
//  mem_ready    in   1  memory access completes this cycle
//  iord         out  1  0=PC addresses memory, 1=ALUOut addresses memory
//  memread      out  1  memory read strobe
//  memwrite     out  1  memory write strobe
//  irwrite      out  1  load IR
//  pcwrite      out  1  unconditional PC load
//  pcwritecond  out  1  PC load if ALU zero
//  pcsrc        out  2  00 ALU result, 01 ALUOut, 10 jump target
//  alusrca      out  1  0=PC, 1=reg A
//  alusrcb      out  2  00 reg B, 01 const 4, 10 ext(imm), 11 ext(imm)<<2
//  aluop        out  2  00 add, 01 sub, 10 funct field, 11 logical-imm (ALU control decodes op)
//  extop        out  1  1=sign-extend imm[15:0], 0=zero-extend
//  regdst       out  1  0=rt, 1=rd
//  memtoreg     out  1  0=ALUOut, 1=MDR
//  regwrite     out  1  register file write
//  illegal_op   out  1  sticky; unsupported opcode was decoded
//  state        out  4  current state (debug)
// BEHAVIOUR
//  - reset_n=0: state=IDLE immediately; all outputs 0. IDLE->FETCH unconditionally on the next clk edge.
//  - Outputs decode combinationally from state and op_q only. An output not listed for a state is 0.
//  - op_q: internal register loaded from op in DECODE. MEMADR and IEXEC use op_q.
//  - Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, andi 001100, ori 001101, j 000010.
//  - State encodings and behaviour:
//    - IDLE(0): all outputs 0.
//    - FETCH(1): memread, alusrcb=01.
//      - irwrite and pcwrite are 1 only in the cycle mem_ready=1; the FSM holds in FETCH otherwise.
//      - Exactly one IR/PC load per fetch.
//    - DECODE(2): alusrcb=11, extop=1 (branch target into ALUOut). Next state by op:
//      - R->EXEC; lw/sw->MEMADR; beq->BRANCH; addi/andi/ori->IEXEC; j->JUMP; any other->TRAP.
//    - MEMADR(3): alusrca, alusrcb=10, extop=1, aluop=00. Next: lw->MEMRD, sw->MEMWR.
//    - MEMRD(4): iord, memread. Holds until mem_ready, then ->MEMWB.
//    - MEMWB(5): regwrite, memtoreg. Next ->FETCH.
//    - MEMWR(6): iord, memwrite. Holds until mem_ready, then ->FETCH. memwrite stays high through the wait.
//    - EXEC(7): alusrca, aluop=10. Next ->ALUWB.
//    - ALUWB(8): regwrite, regdst. Next ->FETCH.
//    - BRANCH(9): alusrca, aluop=01, pcwritecond, pcsrc=01. Next ->FETCH.
//    - IEXEC(10): alusrca, alusrcb=10.
//      - addi: aluop=00, extop=1. andi/ori: aluop=11, extop=0. Next ->IWB.
//    - IWB(11): regwrite (regdst=0, memtoreg=0). Next ->FETCH.
//    - JUMP(12): pcwrite, pcsrc=10. Next ->FETCH.
//    - TRAP(13): all strobes 0, illegal_op=1. Holds until reset.
//  - Codes 14-15 are unreachable. If entered, the next state is IDLE.
//  - Latency with mem_ready=1, counted FETCH to next FETCH:
//    - lw 5 cycles; sw, R, addi/andi/ori 4 cycles; beq, j 3 cycles.
//    - Each mem_ready=0 cycle adds 1 cycle.
//  - Reset mid-instruction aborts the instruction: no further strobes; the next fetch starts 1 cycle after release.
// TESTING
//  - Reset in MEMRD with memread=1 -> same cycle all outputs 0, state=0; after release: 0->1 in 1 cycle.
//  - lw, mem_ready=1 -> state sequence 1,2,3,4,5,1.
//    - extop=1 and alusrcb=10 in state 3; memtoreg=regwrite=1 in state 5.
//  - FETCH with mem_ready low 3 cycles, then high -> irwrite/pcwrite low 3 cycles, high exactly 1 cycle, then DECODE.
//  - beq -> DECODE alusrcb=11, extop=1; BRANCH pcwritecond=1, pcsrc=01, aluop=01; back to FETCH.
//  - ori -> IEXEC extop=0, aluop=11, alusrcb=10; addi -> IEXEC extop=1, aluop=00; IWB regwrite=1, regdst=0.
//  - op=111111 -> state 13, illegal_op=1 held for 20+ cycles; reset_n low -> illegal_op=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath.
// Only the FETCH load strobes look at mem_ready; every other output depends on state and op_q alone.
module mips_multicycle_ctrl #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       extop,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       illegal_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
        S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
        S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_IEXEC = 4'd10, S_IWB = 4'd11,
        S_JUMP = 4'd12, S_TRAP = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     cur, nxt;
    logic [5:0] op_q;
    logic       rdy;

    assign rdy   = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign state = cur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur  <= S_IDLE;
            op_q <= 6'd0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE) op_q <= op;
        end
    end

    // DECODE dispatches on the live opcode; op_q only becomes valid afterwards
    always_comb begin
        nxt = S_IDLE;
        case (cur)
            S_IDLE:   nxt = S_FETCH;
            S_FETCH:  nxt = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_R:                     nxt = S_EXEC;
                    OP_LW, OP_SW:             nxt = S_MEMADR;
                    OP_BEQ:                   nxt = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: nxt = S_IEXEC;
                    OP_J:                     nxt = S_JUMP;
                    default:                  nxt = S_TRAP;
                endcase
            end
            S_MEMADR: nxt = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  nxt = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:  nxt = S_FETCH;
            S_MEMWR:  nxt = rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   nxt = S_ALUWB;
            S_ALUWB:  nxt = S_FETCH;
            S_BRANCH: nxt = S_FETCH;
            S_IEXEC:  nxt = S_IWB;
            S_IWB:    nxt = S_FETCH;
            S_JUMP:   nxt = S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_IDLE;
        endcase
    end

    always_comb begin
        iord = 1'b0; memread = 1'b0; memwrite = 1'b0; irwrite = 1'b0;
        pcwrite = 1'b0; pcwritecond = 1'b0; pcsrc = 2'b00; alusrca = 1'b0;
        alusrcb = 2'b00; aluop = 2'b00; extop = 1'b0; regdst = 1'b0;
        memtoreg = 1'b0; regwrite = 1'b0; illegal_op = 1'b0;
        case (cur)
            S_FETCH: begin
                memread = 1'b1; alusrcb = 2'b01;
                irwrite = rdy;  pcwrite = rdy;
            end
            S_DECODE: begin alusrcb = 2'b11; extop = 1'b1; end
            S_MEMADR: begin alusrca = 1'b1; alusrcb = 2'b10; extop = 1'b1; end
            S_MEMRD:  begin iord = 1'b1; memread = 1'b1; end
            S_MEMWB:  begin regwrite = 1'b1; memtoreg = 1'b1; end
            S_MEMWR:  begin iord = 1'b1; memwrite = 1'b1; end
            S_EXEC:   begin alusrca = 1'b1; aluop = 2'b10; end
            S_ALUWB:  begin regwrite = 1'b1; regdst = 1'b1; end
            S_BRANCH: begin
                alusrca = 1'b1; aluop = 2'b01; pcwritecond = 1'b1; pcsrc = 2'b01;
            end
            S_IEXEC: begin
                alusrca = 1'b1; alusrcb = 2'b10;
                if (op_q == OP_ADDI) begin
                    aluop = 2'b00; extop = 1'b1;
                end else begin
                    aluop = 2'b11; extop = 1'b0;
                end
            end
            S_IWB:    regwrite = 1'b1;
            S_JUMP:   begin pcwrite = 1'b1; pcsrc = 2'b10; end
            S_TRAP:   illegal_op = 1'b1;
            default:  ;
        endcase
    end
endmodule
